// File: rtl/pulse_period_meter_pkg.sv
// Shared types and constants for the pulse period meter.
// PERIOD_W matches the tick generator's terminal-count width, so a measured
// period can be fed straight back to a tick generator.
package pulse_period_meter_pkg;

   localparam int PERIOD_W = 24;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } meter_state_e;

endpackage

// File: rtl/pulse_period_meter_if.sv
// Result channel from the period meter to the MCU-interface logic.
//
// Handshake: the master presents period with period_valid high and holds
// both stable until a cycle in which period_ready is also high; that cycle
// is the transfer. period_ready may toggle freely and does not depend on
// period_valid.
interface pulse_period_meter_if #(
   parameter int W = pulse_period_meter_pkg::PERIOD_W
) ();

   logic [W-1:0] period;
   logic         period_valid;
   logic         period_ready;

   modport master (
      output period,
      output period_valid,
      input  period_ready
   );

   modport slave (
      input  period,
      input  period_valid,
      output period_ready
   );

endinterface

// File: rtl/pulse_period_meter_sync_rise_detect.sv
// Two-flop synchronizer plus delay flop for an asynchronous input, with a
// registered one-cycle rise pulse. Every edge takes the same path, so the
// spacing between rise pulses equals the spacing between input edges.
module pulse_period_meter_sync_rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic dly_q,   dly_d;
   logic rise_q,  rise_d;

   // Next values: shift the input along the chain, flag a 0->1 step.
   always_comb begin
      sync1_d = async_in;
      sync2_d = sync1_q;
      dly_d   = sync2_q;
      rise_d  = sync2_q & ~dly_q;
   end

   // Synchronizer, delay and rise flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dly_q   <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         dly_q   <= dly_d;
         rise_q  <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the spacing between rising edges of an asynchronous pulse line.
// An edge every P cycles reports P-1, the tick generator's terminal-count
// encoding. Results leave through a one-entry valid/ready register; a
// result that finds the register still full is dropped and flags overrun.
module pulse_period_meter
   import pulse_period_meter_pkg::*;
#(
   parameter int          W             = PERIOD_W,
   parameter int unsigned MIN_COUNT     = 0,
   parameter int unsigned TIMEOUT_COUNT = (2**W) - 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       pulse_in,
   input  logic                       clear_overrun,
   output logic                       overrun,
   output logic                       timeout,
   output meter_state_e               dbg_state,
   pulse_period_meter_if.master       out_if
);

   localparam logic [W-1:0] MIN_V     = W'(MIN_COUNT);
   localparam logic [W-1:0] TIMEOUT_V = W'(TIMEOUT_COUNT);

   meter_state_e state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] period_q, period_d;
   logic         valid_q, valid_d;
   logic         overrun_q, overrun_d;
   logic         timeout_q, timeout_d;

   logic         rise;
   logic         min_ok;
   logic         capture;
   logic [W-1:0] capture_val;

   pulse_period_meter_sync_rise_detect u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (pulse_in),
      .rise     (rise)
   );

   // With no glitch threshold every edge is long enough; avoids a
   // constant unsigned comparison against zero.
   generate
      if (MIN_COUNT == 0) begin : g_no_min
         assign min_ok = 1'b1;
      end else begin : g_min
         assign min_ok = (cnt_q >= MIN_V);
      end
   endgenerate

   // FSM next state, counter and capture decision.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      timeout_d   = 1'b0;
      capture     = 1'b0;
      capture_val = cnt_q;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (rise) begin
                  state_d = MEASURE;
               end
            end
            MEASURE: begin
               if (rise && min_ok) begin
                  // Edge wins over a timeout landing in the same cycle.
                  capture = 1'b1;
                  cnt_d   = '0;
               end else if (cnt_q == TIMEOUT_V) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt_q + W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Output register and sticky overrun; a set beats a same-cycle clear.
   always_comb begin
      period_d  = period_q;
      valid_d   = valid_q;
      overrun_d = overrun_q & ~clear_overrun;
      if (capture) begin
         if (!valid_q || out_if.period_ready) begin
            period_d = capture_val;
            valid_d  = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && out_if.period_ready) begin
         valid_d = 1'b0;
      end
   end

   // State, counter and output flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
      end
   end

   assign out_if.period       = period_q;
   assign out_if.period_valid = valid_q;
   assign overrun             = overrun_q;
   assign timeout             = timeout_q;
   assign dbg_state           = state_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: edge trains with known spacing, expected
// periods queued as edges are driven and compared when the DUT hands a
// result over the valid/ready channel.
module tb_pulse_period_meter;
   import pulse_period_meter_pkg::*;

   localparam int W       = 16;
   localparam int MIN_C   = 4;
   localparam int TO_C    = 20;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic         pulse_in;
   logic         clear_overrun;
   logic         overrun;
   logic         timeout;
   meter_state_e dbg_state;

   pulse_period_meter_if #(.W(W)) out_if ();

   pulse_period_meter #(
      .W             (W),
      .MIN_COUNT     (MIN_C),
      .TIMEOUT_COUNT (TO_C)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .pulse_in      (pulse_in),
      .clear_overrun (clear_overrun),
      .overrun       (overrun),
      .timeout       (timeout),
      .dbg_state     (dbg_state),
      .out_if        (out_if)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;
   int timeout_cnt = 0;
   int timeout_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Pop and compare on every completed transfer; also count timeout pulses.
   always @(negedge clk) begin
      if (!reset) begin
         if (out_if.period_valid && out_if.period_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 32'(out_if.period), 32'hFFFF_FFFF);
            end else begin
               check("period", 32'(out_if.period), 32'(exp_q.pop_front()));
            end
         end
         if (timeout) begin
            timeout_cnt++;
            timeout_cyc = cyc;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Rising edge now; the next edge driven by the caller lands gap cycles later.
   task automatic pulse_then_wait(input int gap);
      pulse_in = 1'b1;
      step(1);
      pulse_in = 1'b0;
      step(gap - 1);
   endtask

   task automatic drive_train(input int gap, input int n_edges);
      for (int i = 0; i < n_edges; i++) begin
         if (i > 0) exp_q.push_back(W'(gap - 1));
         pulse_then_wait(gap);
      end
   endtask

   // Drop enable briefly to return the FSM to IDLE.
   task automatic idle_dut();
      enable = 1'b0;
      step(2);
      enable = 1'b1;
      step(1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int c0;
      int to_before;

      reset                = 1'b1;
      enable               = 1'b1;
      pulse_in             = 1'b0;
      clear_overrun        = 1'b0;
      out_if.period_ready  = 1'b1;
      step(3);
      check("rst_period", 32'(out_if.period), 0);
      check("rst_valid", 32'(out_if.period_valid), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_timeout", 32'(timeout), 0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      reset = 1'b0;
      step(2);

      // Edge every 10 cycles: first edge arms, then 9 each time.
      drive_train(10, 5);
      step(2);
      check("t1_overrun", 32'(overrun), 0);
      idle_dut();

      // Glitch rejection: edges at 0, 2, 12 -> only 11 reported.
      pulse_then_wait(2);
      pulse_then_wait(10);
      exp_q.push_back(W'(11));
      pulse_then_wait(6);
      idle_dut();
      check("t2_no_timeout", 32'(timeout_cnt), 0);

      // Timeout: single edge then silence.
      c0 = cyc;
      pulse_then_wait(2);
      for (int i = 0; i < 40 && timeout_cnt == 0; i++) step(1);
      check("t3_timeout_cnt", 32'(timeout_cnt), 1);
      check("t3_timeout_cyc", 32'(timeout_cyc), 32'(c0 + 25));
      check("t3_state", 32'(dbg_state), 32'(IDLE));
      step(5);
      check("t3_single_pulse", 32'(timeout_cnt), 1);
      pulse_then_wait(5);
      exp_q.push_back(W'(4));
      pulse_then_wait(6);
      idle_dut();

      // Overrun: consumer stalled, edges every 8.
      out_if.period_ready = 1'b0;
      pulse_then_wait(8);
      pulse_then_wait(8);
      pulse_then_wait(8);
      idle_dut();
      check("t4_valid_held", 32'(out_if.period_valid), 1);
      check("t4_period_held", 32'(out_if.period), 7);
      check("t4_overrun", 32'(overrun), 1);
      exp_q.push_back(W'(7));
      out_if.period_ready = 1'b1;
      step(1);
      out_if.period_ready = 1'b0;
      check("t4_valid_drop", 32'(out_if.period_valid), 0);
      check("t4_overrun_sticky", 32'(overrun), 1);
      clear_overrun = 1'b1;
      step(1);
      clear_overrun = 1'b0;
      check("t4_overrun_clr", 32'(overrun), 0);
      out_if.period_ready = 1'b1;

      // Edge exactly at counter == TIMEOUT_COUNT wins.
      to_before = timeout_cnt;
      pulse_then_wait(TO_C + 1);
      exp_q.push_back(W'(TO_C));
      pulse_then_wait(6);
      idle_dut();
      check("t5_no_timeout", 32'(timeout_cnt), 32'(to_before));

      // Enable dropped mid-measurement: nothing reported, next edge re-arms.
      to_before = timeout_cnt;
      pulse_then_wait(8);
      enable = 1'b0;
      step(3);
      enable = 1'b1;
      pulse_then_wait(6);
      exp_q.push_back(W'(5));
      pulse_then_wait(6);
      check("t6_no_timeout", 32'(timeout_cnt), 32'(to_before));
      idle_dut();

      // Reset discards a pending result.
      out_if.period_ready = 1'b0;
      pulse_then_wait(7);
      pulse_then_wait(7);
      check("t6_valid_pending", 32'(out_if.period_valid), 1);
      reset = 1'b1;
      step(1);
      check("t6_rst_valid", 32'(out_if.period_valid), 0);
      check("t6_rst_period", 32'(out_if.period), 0);
      check("t6_rst_state", 32'(dbg_state), 32'(IDLE));
      reset = 1'b0;
      out_if.period_ready = 1'b1;
      step(4);
      check("sb_empty", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Receive-side counterpart of the team's periodic tick generator: measures the clock-cycle spacing between rising edges of an external, asynchronous pulse line.
- Reports each measurement in the same encoding the tick generator takes as its terminal count: an edge every P cycles reports P-1.
- Result is delivered through a one-entry valid/ready output register to the MCU-interface logic.
- Used to characterise incoming sensor/MCU pulse trains and to close the loop on locally generated ticks.

Parameters:
- W, 24, width of the internal counter and of the reported period.
- MIN_COUNT, 0, edges arriving while the counter is below this value are rejected as glitches.
- TIMEOUT_COUNT, 2**24-1, counter value at which a measurement is abandoned; must be at most 2**W-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  measurement enable; low forces IDLE.
- pulse_in  in  1  asynchronous pulse line.
- clear_overrun  in  1  single-cycle clear of the sticky overrun flag.
- period  out  W  last accepted measurement, in edge spacing minus 1.
- period_valid  out  1  period holds an unconsumed result.
- period_ready  in  1  consumer accepts period when high together with period_valid.
- overrun  out  1  sticky: a measurement was dropped because the output was still full.
- timeout  out  1  one-cycle pulse when a measurement is abandoned.

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous, active-high. Reset clears all state: period=0, period_valid=0, overrun=0, timeout=0, counter=0, FSM=IDLE, synchronizer flops=0.
- Input conditioning: pulse_in passes through a 2-flop synchronizer plus a delay flop. rise is high for one cycle on a 0->1 transition of the synchronized signal. Latency from pulse_in to rise is 3 clk. Every edge sees the same delay, so spacing is preserved.

FSM states:
- IDLE: counter held at 0. Transitions to MEASURE when enable and rise.
- MEASURE: counts each cycle, counter <= counter+1.

MEASURE, each cycle:
- rise && counter>=MIN_COUNT:
  - Capture counter as the measurement; counter <= 0; stay in MEASURE.
  - An edge at cycle t followed by an edge at t+P captures P-1.
- rise && counter<MIN_COUNT: edge ignored; counting continues.
- !rise && counter==TIMEOUT_COUNT: timeout=1 for one cycle; counter <= 0; go to IDLE. No measurement.
- Same cycle rise && counter==TIMEOUT_COUNT: the edge wins. Capture TIMEOUT_COUNT as the measurement; no timeout pulse.

Output register:
- A capture with period_valid==0, or with period_valid && period_ready in the same cycle: period <= captured value; period_valid=1 on the next cycle.
- A capture with period_valid && !period_ready: new value dropped, period unchanged, overrun <= 1.
- period_valid && period_ready with no capture: period_valid <= 0; period retains its value.
- overrun stays set until clear_overrun or reset. A simultaneous set and clear leaves overrun set.

Enable and reset mid-operation:
- enable low in any state: next state IDLE, counter 0, no capture, no timeout. The output register and overrun are unaffected.
- After re-enable, the first edge only arms MEASURE; it reports nothing.
- reset mid-measurement: everything returns to reset values next cycle, including discarding a pending period_valid.

Counter width: W bits; it never wraps, because TIMEOUT_COUNT <= 2**W-1 bounds it.

Decomposition:
- Shared package: FSM state enum {IDLE, MEASURE}; the default width constant PERIOD_W=24, shared with the tick generator's terminal-count port width.
- One natural sub-module: sync_rise_detect (2-flop synchronizer plus edge detector, outputs the one-cycle rise). Reusable for the other asynchronous inputs in the codebase.

Test Plan:
- Edge every 10 cycles (tick generator with terminal count 9, looped back), enable=1, period_ready=1 -> first edge arms only; then period=9 with a one-cycle period_valid every 10 cycles; overrun=0.
- MIN_COUNT=4; edges at cycles 0, 2, 12 -> the edge at 2 is ignored; period=11.
- TIMEOUT_COUNT=20; one edge then silence -> timeout pulses once 21 cycles after the arming edge; FSM in IDLE. A later pair of edges 5 apart -> period=4.
- period_ready=0, edges every 8 cycles -> first result period=7 held; the second capture sets overrun=1 with period still 7. Raise period_ready for one cycle -> valid drops. Pulse clear_overrun -> overrun=0.
- Edge landing exactly when counter==TIMEOUT_COUNT -> period=TIMEOUT_COUNT reported, no timeout pulse.
- Mid-measurement: drop enable for 3 cycles then raise it -> no result and no timeout; the next edge only re-arms. Assert reset with period_valid=1 -> period_valid=0 and period=0 next cycle.
